thread_regfile_sb: RTL and testbench

- Per-thread register file, parametrised successor of the fixed 16x8 thread register file.
- Configurable register count and data width; read-only special registers sit at the top of the address space.
- %blockIdx is loaded on an explicit dispatch strobe instead of every cycle.
- Loads are non-blocking: an LDR marks its destination pending, and the LSU writes back later on a second write port. A scoreboard raises a hazard to the decoder/scheduler, which stalls while it is high.

---
 rtl/core_states_pkg.sv | 15 +
 rtl/reg_pkg.sv | 16 +
 rtl/reg_scoreboard.sv | 52 +++++
 rtl/thread_regfile_sb.sv | 166 ++++++++++++++++
 tb/tb_thread_regfile_sb.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_states_pkg.sv
// Core pipeline state encoding shared by the scheduler and per-thread units.
package core_states_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'b000,
        FETCH   = 3'b001,
        DECODE  = 3'b010,
        REQUEST = 3'b011,
        WAIT    = 3'b100,
        EXECUTE = 3'b101,
        UPDATE  = 3'b110,
        DONE    = 3'b111
    } core_state_e;

endpackage

// File: rtl/reg_pkg.sv
// Register-file write-source encoding and layout of the read-only special registers.
package reg_pkg;

    typedef enum logic [1:0] {
        ARITHMETIC = 2'b00,
        MEMORY     = 2'b01,
        CONSTANT   = 2'b10
    } optype_e;

    // Special registers occupy the top RO_COUNT addresses; offsets count down from NUM_REGS.
    localparam int RO_COUNT       = 3;
    localparam int BLOCK_IDX_OFS  = 3;
    localparam int BLOCK_DIM_OFS  = 2;
    localparam int THREAD_IDX_OFS = 1;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-load scoreboard: one bit per register, set on LDR issue, cleared on LSU writeback.
module reg_scoreboard #(
    parameter int NUM_REGS = 16,
    localparam int ADDR_BITS = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 set_en,
    input  logic [ADDR_BITS-1:0] set_addr,
    input  logic                 clr_en,
    input  logic [ADDR_BITS-1:0] clr_addr,
    input  logic [ADDR_BITS-1:0] query_rs,
    input  logic [ADDR_BITS-1:0] query_rt,
    input  logic [ADDR_BITS-1:0] query_rd,
    output logic                 hit_rs,
    output logic                 hit_rt,
    output logic                 hit_rd,
    output logic                 pending_any
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [DEPTH-1:0] pending;
    logic [DEPTH-1:0] pending_nxt;

    // Set is applied after clear so a same-cycle set/clear of one bit leaves it set.
    always_comb begin
        // NOTE: default first, so every path assigns pending_nxt and no latch is inferred.
        pending_nxt = pending;
        if (clr_en) begin
            pending_nxt[clr_addr] = 1'b0;
        end
        if (set_en) begin
            pending_nxt[set_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: non-blocking assignments for state, so all flops update from pre-edge values.
        if (!reset_n) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    assign hit_rs      = pending[query_rs];
    assign hit_rt      = pending[query_rt];
    assign hit_rd      = pending[query_rd];
    assign pending_any = |pending;

endmodule

// File: rtl/thread_regfile_sb.sv
// Per-thread register file with read-only special registers and non-blocking load scoreboard.
module thread_regfile_sb
    import reg_pkg::*, core_states_pkg::*;
#(
    parameter int NUM_REGS          = 16,
    parameter int DATA_BITS         = 8,
    parameter int THREADS_PER_BLOCK = 4,
    parameter int THREAD_ID         = 0,
    localparam int ADDR_BITS        = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 block_start,
    input  logic [DATA_BITS-1:0] block_id,
    input  logic [2:0]           core_state,
    input  logic [ADDR_BITS-1:0] decoded_rd_address,
    input  logic [ADDR_BITS-1:0] decoded_rs_address,
    input  logic [ADDR_BITS-1:0] decoded_rt_address,
    input  logic                 decoded_reg_write_enable,
    input  logic [1:0]           decoded_reg_input_mux,
    input  logic [DATA_BITS-1:0] decoded_immediate,
    input  logic [DATA_BITS-1:0] alu_out,
    input  logic                 lsu_wb_valid,
    input  logic [ADDR_BITS-1:0] lsu_wb_address,
    input  logic [DATA_BITS-1:0] lsu_out,
    output logic [DATA_BITS-1:0] rs,
    output logic [DATA_BITS-1:0] rt,
    output logic                 hazard,
    output logic                 pending_any
);

    localparam int DEPTH = 1 << ADDR_BITS;

    localparam logic [ADDR_BITS-1:0] BLOCK_IDX_ADDR  = ADDR_BITS'(NUM_REGS - BLOCK_IDX_OFS);
    localparam logic [ADDR_BITS-1:0] BLOCK_DIM_ADDR  = ADDR_BITS'(NUM_REGS - BLOCK_DIM_OFS);
    localparam logic [ADDR_BITS-1:0] THREAD_IDX_ADDR = ADDR_BITS'(NUM_REGS - THREAD_IDX_OFS);
    localparam logic [DATA_BITS-1:0] BLOCK_DIM_VAL   = DATA_BITS'(THREADS_PER_BLOCK);
    localparam logic [DATA_BITS-1:0] THREAD_ID_VAL   = DATA_BITS'(THREAD_ID);

    logic [DATA_BITS-1:0] regs [DEPTH];
    logic [DATA_BITS-1:0] block_idx;

    logic                 hit_rs;
    logic                 hit_rt;
    logic                 hit_rd;
    logic                 wb_fire;
    logic                 upd_fire;
    logic                 read_fire;
    logic                 upd_wr_en;
    logic                 ldr_issue;
    logic [DATA_BITS-1:0] upd_wr_data;
    logic [DATA_BITS-1:0] rs_next;
    logic [DATA_BITS-1:0] rt_next;

    // Anything at or above %blockIdx (including unused addresses when NUM_REGS is not a power of two).
    function automatic logic is_general(input logic [ADDR_BITS-1:0] addr);
        return addr < BLOCK_IDX_ADDR;
    endfunction

    function automatic logic [DATA_BITS-1:0] operand(input logic [ADDR_BITS-1:0] addr);
        if (wb_fire && lsu_wb_address == addr) begin
            return lsu_out;
        end
        if (block_start && addr == BLOCK_IDX_ADDR) begin
            return block_id;
        end
        if (addr == BLOCK_IDX_ADDR) begin
            return block_idx;
        end
        if (addr == BLOCK_DIM_ADDR) begin
            return BLOCK_DIM_VAL;
        end
        if (addr == THREAD_IDX_ADDR) begin
            return THREAD_ID_VAL;
        end
        if (is_general(addr)) begin
            return regs[addr];
        end
        return '0;
    endfunction

    assign wb_fire   = lsu_wb_valid && is_general(lsu_wb_address);
    assign read_fire = enable && (core_state == REQUEST);
    assign upd_fire  = enable && (core_state == UPDATE) && decoded_reg_write_enable
                    && is_general(decoded_rd_address) && !hit_rd;

    always_comb begin
        upd_wr_en   = 1'b0;
        upd_wr_data = alu_out;
        ldr_issue   = 1'b0;
        if (upd_fire) begin
            case (decoded_reg_input_mux)
                ARITHMETIC: begin
                    upd_wr_en   = 1'b1;
                    upd_wr_data = alu_out;
                end
                CONSTANT: begin
                    upd_wr_en   = 1'b1;
                    upd_wr_data = decoded_immediate;
                end
                MEMORY:  ldr_issue = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        rs_next = operand(decoded_rs_address);
        rt_next = operand(decoded_rt_address);
    end

    reg_scoreboard #(
        .NUM_REGS(NUM_REGS)
    ) u_scoreboard (
        .clk        (clk),
        .reset_n    (reset_n),
        .set_en     (ldr_issue),
        .set_addr   (decoded_rd_address),
        .clr_en     (wb_fire),
        .clr_addr   (lsu_wb_address),
        .query_rs   (decoded_rs_address),
        .query_rt   (decoded_rt_address),
        .query_rd   (decoded_rd_address),
        .hit_rs     (hit_rs),
        .hit_rt     (hit_rt),
        .hit_rd     (hit_rd),
        .pending_any(pending_any)
    );

    // A writeback colliding with an UPDATE write to the same non-pending register takes precedence.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the array is reset because general registers must read zero after reset.
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            block_idx <= '0;
        end else begin
            if (block_start) begin
                block_idx <= block_id;
            end
            if (upd_wr_en) begin
                regs[decoded_rd_address] <= upd_wr_data;
            end
            if (wb_fire) begin
                regs[lsu_wb_address] <= lsu_out;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rs <= '0;
            rt <= '0;
        end else if (read_fire) begin
            rs <= rs_next;
            rt <= rt_next;
        end
    end

    assign hazard = enable
                 && (core_state == DECODE || core_state == REQUEST || core_state == UPDATE)
                 && (hit_rs || hit_rt || (decoded_reg_write_enable && hit_rd));

endmodule

// File: tb/tb_thread_regfile_sb.sv
// Bench for thread_regfile_sb: a 16x8 and a 32x16 instance, reads scored through expectation queues.
module tb_thread_regfile_sb;
    import core_states_pkg::*;
    import reg_pkg::*;

    typedef struct {
        logic [15:0] rs;
        logic [15:0] rt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        en16, en32;
    logic        block_start;
    logic [15:0] block_id;
    logic [2:0]  core_state;
    logic [4:0]  rd_a, rs_a, rt_a, wb_addr;
    logic        we;
    logic [1:0]  mux;
    logic [15:0] imm, alu, lsu;
    logic        wb_valid;

    logic [7:0]  rs16, rt16;
    logic        hazard16, pa16;
    logic [15:0] rs32, rt32;
    logic        hazard32, pa32;

    int   passed = 0;
    int   total  = 0;
    exp_t q16[$];
    exp_t q32[$];
    bit   due16 = 1'b0;
    bit   due32 = 1'b0;

    always #5 clk = ~clk;

    thread_regfile_sb #(
        .NUM_REGS(16), .DATA_BITS(8), .THREADS_PER_BLOCK(4), .THREAD_ID(2)
    ) dut16 (
        .clk(clk), .reset_n(reset_n), .enable(en16), .block_start(block_start),
        .block_id(block_id[7:0]), .core_state(core_state),
        .decoded_rd_address(rd_a[3:0]), .decoded_rs_address(rs_a[3:0]),
        .decoded_rt_address(rt_a[3:0]), .decoded_reg_write_enable(we),
        .decoded_reg_input_mux(mux), .decoded_immediate(imm[7:0]), .alu_out(alu[7:0]),
        .lsu_wb_valid(wb_valid), .lsu_wb_address(wb_addr[3:0]), .lsu_out(lsu[7:0]),
        .rs(rs16), .rt(rt16), .hazard(hazard16), .pending_any(pa16)
    );

    thread_regfile_sb #(
        .NUM_REGS(32), .DATA_BITS(16), .THREADS_PER_BLOCK(8), .THREAD_ID(5)
    ) dut32 (
        .clk(clk), .reset_n(reset_n), .enable(en32), .block_start(block_start),
        .block_id(block_id), .core_state(core_state),
        .decoded_rd_address(rd_a), .decoded_rs_address(rs_a),
        .decoded_rt_address(rt_a), .decoded_reg_write_enable(we),
        .decoded_reg_input_mux(mux), .decoded_immediate(imm), .alu_out(alu),
        .lsu_wb_valid(wb_valid), .lsu_wb_address(wb_addr), .lsu_out(lsu),
        .rs(rs32), .rt(rt32), .hazard(hazard32), .pending_any(pa32)
    );

    // A REQUEST seen at one falling edge has its operands registered by the next one.
    always @(negedge clk) begin
        exp_t e;
        if (due16) begin
            total++;
            if (q16.size() == 0) begin
                $display("FAIL read16_unexpected got rs=%h rt=%h required no read", rs16, rt16);
            end else begin
                e = q16.pop_front();
                if (rs16 !== e.rs[7:0] || rt16 !== e.rt[7:0])
                    $display("FAIL read16 got rs=%h rt=%h required rs=%h rt=%h",
                             rs16, rt16, e.rs[7:0], e.rt[7:0]);
                else passed++;
            end
        end
        if (due32) begin
            total++;
            if (q32.size() == 0) begin
                $display("FAIL read32_unexpected got rs=%h rt=%h required no read", rs32, rt32);
            end else begin
                e = q32.pop_front();
                if (rs32 !== e.rs || rt32 !== e.rt)
                    $display("FAIL read32 got rs=%h rt=%h required rs=%h rt=%h",
                             rs32, rt32, e.rs, e.rt);
                else passed++;
            end
        end
        due16 = reset_n && en16 && (core_state == REQUEST);
        due32 = reset_n && en32 && (core_state == REQUEST);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read16(input logic [4:0] a, input logic [4:0] b,
                          input logic [15:0] ers, input logic [15:0] ert);
        q16.push_back('{ers, ert});
        en16 = 1'b1; en32 = 1'b0;
        core_state = REQUEST; rs_a = a; rt_a = b;
        tick();
        core_state = IDLE;
    endtask

    task automatic read32(input logic [4:0] a, input logic [4:0] b,
                          input logic [15:0] ers, input logic [15:0] ert);
        q32.push_back('{ers, ert});
        en16 = 1'b0; en32 = 1'b1;
        core_state = REQUEST; rs_a = a; rt_a = b;
        tick();
        core_state = IDLE;
    endtask

    // The unused write source carries the complement so a wrong mux selection is visible.
    task automatic upd(input bit sel32, input logic [4:0] d, input logic [1:0] m,
                       input logic [15:0] value);
        en16 = !sel32; en32 = sel32;
        core_state = UPDATE; we = 1'b1; rd_a = d; mux = m;
        alu = (m == ARITHMETIC) ? value : ~value;
        imm = (m == CONSTANT)   ? value : ~value;
        tick();
        core_state = IDLE; we = 1'b0; en16 = 1'b0; en32 = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if (rs16 !== 8'h00 || rt16 !== 8'h00) $display("FAIL reset_operands got rs=%h rt=%h required 00", rs16, rt16);
        else passed++;
        total++;
        if (pa16 !== 1'b0 || hazard16 !== 1'b0) $display("FAIL reset_pending got pa=%b hz=%b required 0", pa16, hazard16);
        else passed++;
        reset_n = 1'b1;
        tick();
        read16(5'd14, 5'd15, 16'h0004, 16'h0002);
        for (int r = 0; r <= 12; r++) read16(5'(r), 5'(12 - r), 16'h0000, 16'h0000);
    endtask

    task automatic test_block_start();
        block_start = 1'b1; block_id = 16'h0007;
        tick();
        block_start = 1'b0;
        read16(5'd13, 5'd14, 16'h0007, 16'h0004);
        block_start = 1'b1; block_id = 16'h0009;
        read16(5'd13, 5'd15, 16'h0009, 16'h0002);
        block_start = 1'b0;
        read16(5'd13, 5'd13, 16'h0009, 16'h0009);
    endtask

    task automatic test_writes();
        upd(1'b0, 5'd3, CONSTANT, 16'h005A);
        read16(5'd3, 5'd0, 16'h005A, 16'h0000);
        upd(1'b0, 5'd14, ARITHMETIC, 16'h00FF);
        read16(5'd14, 5'd3, 16'h0004, 16'h005A);
        upd(1'b0, 5'd4, 2'b11, 16'h0077);
        read16(5'd4, 5'd4, 16'h0000, 16'h0000);
    endtask

    task automatic test_load_hazard();
        upd(1'b0, 5'd5, MEMORY, 16'h0000);
        total++;
        if (pa16 !== 1'b1) $display("FAIL ldr_pending_any got=%b required=1", pa16);
        else passed++;
        en16 = 1'b1; core_state = DECODE; rs_a = 5'd0; rt_a = 5'd0; rd_a = 5'd5; we = 1'b1;
        #1;
        total++;
        if (hazard16 !== 1'b1) $display("FAIL hazard_rd got=%b required=1", hazard16);
        else passed++;
        we = 1'b0;
        #1;
        total++;
        if (hazard16 !== 1'b0) $display("FAIL hazard_rd_no_we got=%b required=0", hazard16);
        else passed++;
        rs_a = 5'd5;
        #1;
        total++;
        if (hazard16 !== 1'b1) $display("FAIL hazard_rs got=%b required=1", hazard16);
        else passed++;
        en16 = 1'b0;
        #1;
        total++;
        if (hazard16 !== 1'b0) $display("FAIL hazard_disabled got=%b required=0", hazard16);
        else passed++;
        en16 = 1'b1;
        tick();
        tick();
        wb_valid = 1'b1; wb_addr = 5'd5; lsu = 16'h0033;
        #1;
        total++;
        if (hazard16 !== 1'b1) $display("FAIL hazard_during_wb got=%b required=1", hazard16);
        else passed++;
        tick();
        wb_valid = 1'b0;
        total++;
        if (hazard16 !== 1'b0 || pa16 !== 1'b0)
            $display("FAIL hazard_after_wb got hz=%b pa=%b required 0", hazard16, pa16);
        else passed++;
        core_state = IDLE;
        read16(5'd5, 5'd0, 16'h0033, 16'h0000);
    endtask

    task automatic test_forwarding();
        wb_valid = 1'b1; wb_addr = 5'd5; lsu = 16'h0044;
        read16(5'd5, 5'd5, 16'h0044, 16'h0044);
        wb_valid = 1'b0;
        read16(5'd5, 5'd3, 16'h0044, 16'h005A);
        wb_valid = 1'b1; wb_addr = 5'd6; lsu = 16'h0066;
        upd(1'b0, 5'd2, ARITHMETIC, 16'h0010);
        wb_valid = 1'b0;
        read16(5'd2, 5'd6, 16'h0010, 16'h0066);
    endtask

    task automatic test_reset_flush16();
        upd(1'b0, 5'd7, MEMORY, 16'h0000);
        total++;
        if (pa16 !== 1'b1) $display("FAIL flush16_pending got=%b required=1", pa16);
        else passed++;
        reset_n = 1'b0;
        #1;
        total++;
        if (pa16 !== 1'b0 || rs16 !== 8'h00) $display("FAIL flush16_async got pa=%b rs=%h required 0/00", pa16, rs16);
        else passed++;
        tick();
        reset_n = 1'b1;
        wb_valid = 1'b1; wb_addr = 5'd7; lsu = 16'h0021;
        tick();
        wb_valid = 1'b0;
        total++;
        if (pa16 !== 1'b0) $display("FAIL flush16_late_wb got=%b required=0", pa16);
        else passed++;
        read16(5'd7, 5'd13, 16'h0021, 16'h0000);
    endtask

    task automatic test_wide();
        read32(5'd29, 5'd30, 16'h0000, 16'h0008);
        read32(5'd31, 5'd28, 16'h0005, 16'h0000);
        block_start = 1'b1; block_id = 16'hBEEF;
        tick();
        block_start = 1'b0;
        read32(5'd29, 5'd29, 16'hBEEF, 16'hBEEF);
        upd(1'b1, 5'd28, CONSTANT, 16'h1234);
        upd(1'b1, 5'd29, CONSTANT, 16'hAAAA);
        read32(5'd28, 5'd29, 16'h1234, 16'hBEEF);
        upd(1'b1, 5'd7, MEMORY, 16'h0000);
        total++;
        if (pa32 !== 1'b1 || pa16 !== 1'b0) $display("FAIL wide_ldr got pa32=%b pa16=%b required 1/0", pa32, pa16);
        else passed++;
        reset_n = 1'b0;
        #1;
        total++;
        if (pa32 !== 1'b0) $display("FAIL wide_flush_async got=%b required=0", pa32);
        else passed++;
        tick();
        reset_n = 1'b1;
        wb_valid = 1'b1; wb_addr = 5'd7; lsu = 16'h4321;
        tick();
        wb_valid = 1'b0;
        read32(5'd7, 5'd29, 16'h4321, 16'h0000);
    endtask

    initial begin
        reset_n = 1'b0; en16 = 1'b0; en32 = 1'b0; block_start = 1'b0; block_id = '0;
        core_state = IDLE; rd_a = '0; rs_a = '0; rt_a = '0; wb_addr = '0;
        we = 1'b0; mux = '0; imm = '0; alu = '0; lsu = '0; wb_valid = 1'b0;
        tick();
        tick();
        test_reset();
        test_block_start();
        test_writes();
        test_load_hazard();
        test_forwarding();
        test_reset_flush16();
        test_wide();
        tick();
        tick();
        total++;
        if (q16.size() != 0 || q32.size() != 0)
            $display("FAIL reads_outstanding got q16=%0d q32=%0d required 0", q16.size(), q32.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
